serial_addsub: RTL and testbench

Parametrised multi-cycle add/subtract unit that processes operands DIGIT bits per clock through a registered carry/borrow chain. It is the sequential successor to the single-bit full-subtractor cells: one cell slice is reused across cycles instead of replicating WIDTH cells. It accepts an operation with a start pulse, reports completion with a one-cycle done pulse and holds flags until the next completion. It sits beside the ALU datapath wherever area matters more than latency.

---
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_addsub.sv | 138 +++++++++++++
 tb/tb_serial_addsub.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Request/response bundle of the digit-serial add/subtract unit.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, mode, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: DIGIT bits per clock through one reused cell slice
// and a registered carry/borrow flop; result and flags held until next completion.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int unsigned K  = WIDTH / DIGIT;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             mode_q, mode_d, chain_q, chain_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [DIGIT-1:0] dig_c;
  logic             chain_c;
  logic [WIDTH-1:0] res_next_c;

  // One digit of ripple through DIGIT add or subtract cells.
  always_comb begin
    logic c, x, y;
    c     = chain_q;
    dig_c = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      x        = a_q[i];
      y        = b_q[i];
      dig_c[i] = x ^ y ^ c;
      if (mode_q) c = (x & y) | ((x ^ y) & c);
      else        c = (~x & y) | (~(x ^ y) & c);
    end
    chain_c    = c;
    res_next_c = WIDTH'(res_q >> DIGIT) | (WIDTH'(dig_c) << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    mode_d   = mode_q;
    chain_d  = chain_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          chain_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_next_c;
        chain_d = chain_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) begin
          state_d  = DONE;
          result_d = res_next_c;
          cout_d   = chain_c;
          zero_d   = (res_next_c == '0);
          // Overflow judged on the MSBs of the operands as captured.
          ovf_d    = mode_q ? ((a_msb_q == b_msb_q) && (res_next_c[WIDTH-1] != a_msb_q))
                            : ((a_msb_q != b_msb_q) && (res_next_c[WIDTH-1] != a_msb_q));
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      mode_q   <= 1'b0;
      chain_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      mode_q   <= mode_d;
      chain_q  <= chain_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and exhaustive checks of serial_addsub at WIDTH 8 and WIDTH 4.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] prev8 = '0;

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) if8 ();
  serial_addsub_if #(.WIDTH(4)) if41 ();
  serial_addsub_if #(.WIDTH(4)) if42 ();
  serial_addsub_if #(.WIDTH(4)) if44 ();

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_addsub #(.WIDTH(4), .DIGIT(1)) u41 (.clk(clk), .rst_n(rst_n), .bus(if41.slave));
  serial_addsub #(.WIDTH(4), .DIGIT(2)) u42 (.clk(clk), .rst_n(rst_n), .bus(if42.slave));
  serial_addsub #(.WIDTH(4), .DIGIT(4)) u44 (.clk(clk), .rst_n(rst_n), .bus(if44.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack8();
    return {21'd0, if8.cout, if8.ovf, if8.zero, if8.result};
  endfunction

  // Reference: {cout, ovf, zero, result} from plain integer arithmetic.
  function automatic logic [31:0] model4(input logic m, input logic [3:0] a, input logic [3:0] b);
    int sa, sb, sr;
    logic [4:0] ext;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    if (m) begin ext = {1'b0, a} + {1'b0, b}; sr = sa + sb; end
    else   begin ext = {1'b0, a} - {1'b0, b}; sr = sa - sb; end
    return {25'd0, ext[4], (sr < -8 || sr > 7), (ext[3:0] == 4'd0), ext[3:0]};
  endfunction

  task automatic go8(input logic m, input logic [7:0] a, input logic [7:0] b);
    if8.mode  = m;
    if8.a     = a;
    if8.b     = b;
    if8.start = 1'b1;
  endtask

  // Accepting edge, then count cycles to done (bounded); optional stray start at RUN cycle 3.
  task automatic wait8(input string tag, input bit inj, output int cyc, output int busyc);
    @(posedge clk); #1;
    if8.start = 1'b0;
    cyc = 20;
    busyc = 0;
    chk({tag, "_hold"}, pack8(), prev8);
    if (if8.busy) busyc++;
    for (int k = 1; k < 20; k++) begin
      if (inj && k == 3) begin
        if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h11; if8.mode = 1'b1;
      end
      @(posedge clk); #1;
      if8.start = 1'b0;
      if (if8.done) begin cyc = k; break; end
      if (if8.busy) busyc++;
    end
  endtask

  task automatic op8(input string tag, input logic m, input logic [7:0] a, input logic [7:0] b,
                     input bit inj, input logic [31:0] exp);
    int cyc, busyc;
    go8(m, a, b);
    wait8(tag, inj, cyc, busyc);
    chk({tag, "_lat"}, 32'(cyc), 32'd8);
    chk({tag, "_busy"}, 32'(busyc), 32'd8);
    chk({tag, "_res"}, pack8(), exp);
    prev8 = exp;
  endtask

  initial begin
    int cyc, busyc, seen;
    logic [31:0] e;
    if8.start = 0;  if8.mode = 0;  if8.a = '0;  if8.b = '0;
    if41.start = 0; if41.mode = 0; if41.a = '0; if41.b = '0;
    if42.start = 0; if42.mode = 0; if42.a = '0; if42.b = '0;
    if44.start = 0; if44.mode = 0; if44.a = '0; if44.b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(if8.busy), 32'd0);
    chk("rst_done", 32'(if8.done), 32'd0);
    chk("rst_flags", pack8(), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8("sub_05_03", 1'b0, 8'h05, 8'h03, 1'b0, 32'h002);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(if8.done), 32'd0);
    chk("res_held", pack8(), 32'h002);
    op8("sub_03_05", 1'b0, 8'h03, 8'h05, 1'b0, 32'h4FE);
    op8("sub_80_01", 1'b0, 8'h80, 8'h01, 1'b0, 32'h27F);
    op8("sub_5a_5a", 1'b0, 8'h5A, 8'h5A, 1'b0, 32'h100);
    op8("add_ff_01", 1'b1, 8'hFF, 8'h01, 1'b0, 32'h500);
    op8("add_7f_01", 1'b1, 8'h7F, 8'h01, 1'b0, 32'h280);
    op8("ignore_start", 1'b0, 8'h05, 8'h03, 1'b1, 32'h002);

    // Start presented in the done cycle: next done lands K+1 cycles later.
    go8(1'b1, 8'h7F, 8'h01);
    wait8("b2b", 1'b0, cyc, busyc);
    chk("b2b_lat", 32'(cyc + 1), 32'd9);
    chk("b2b_res", pack8(), 32'h280);
    prev8 = 32'h280;

    // Reset in RUN cycle 4 clears everything and suppresses done.
    go8(1'b1, 8'h10, 8'h20);
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(if8.busy), 32'd0);
    chk("midrst_done", 32'(if8.done), 32'd0);
    chk("midrst_flags", pack8(), 32'd0);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (if8.done) seen++;
    end
    chk("midrst_nodone", 32'(seen), 32'd0);
    rst_n = 1'b1;
    prev8 = '0;
    @(posedge clk); #1;
    op8("after_rst", 1'b1, 8'h10, 8'h20, 1'b0, 32'h030);

    // WIDTH 4, DIGIT 1/2/4 run in lockstep over every operand pair and mode.
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          if41.mode = 1'(m); if41.a = 4'(a); if41.b = 4'(b); if41.start = 1'b1;
          if42.mode = 1'(m); if42.a = 4'(a); if42.b = 4'(b); if42.start = 1'b1;
          if44.mode = 1'(m); if44.a = 4'(a); if44.b = 4'(b); if44.start = 1'b1;
          e = model4(1'(m), 4'(a), 4'(b));
          @(posedge clk); #1;
          if41.start = 1'b0; if42.start = 1'b0; if44.start = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("w4d1_done", 32'(if41.done), 32'(k == 4));
            chk("w4d2_done", 32'(if42.done), 32'(k == 2));
            chk("w4d4_done", 32'(if44.done), 32'(k == 1));
            if (k == 4) chk("w4d1_res", {25'd0, if41.cout, if41.ovf, if41.zero, if41.result}, e);
            if (k == 2) chk("w4d2_res", {25'd0, if42.cout, if42.ovf, if42.zero, if42.result}, e);
            if (k == 1) chk("w4d4_res", {25'd0, if44.cout, if44.ovf, if44.zero, if44.result}, e);
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
